// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode side signals of the fetch queue
interface fetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 16,
  parameter int ENQ_W  = 2,
  parameter int DEQ_W  = 2
);
  localparam int EW  = $clog2(ENQ_W + 1);
  localparam int DQW = $clog2(DEQ_W + 1);
  localparam int CW  = $clog2(DEPTH + 1);

  logic                    flush;
  logic                    req_inflight;
  logic                    imem_resp;
  logic [EW-1:0]           enq_cnt;
  logic [ENQ_W*DATA_W-1:0] enq_data;
  logic [ENQ_W*PC_W-1:0]   enq_pc;
  logic                    enq_ready;
  logic [DQW-1:0]          deq_cnt;
  logic [DEQ_W-1:0]        deq_valid;
  logic [DEQ_W*DATA_W-1:0] deq_data;
  logic [DEQ_W*PC_W-1:0]   deq_pc;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;

  modport master (
    output flush, req_inflight, imem_resp, enq_cnt, enq_data, enq_pc, deq_cnt,
    input  enq_ready, deq_valid, deq_data, deq_pc, count, full, empty
  );

  modport slave (
    input  flush, req_inflight, imem_resp, enq_cnt, enq_data, enq_pc, deq_cnt,
    output enq_ready, deq_valid, deq_data, deq_pc, count, full, empty
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - multi-lane show-ahead instruction queue with flush and stale-response squash
module fetch_queue #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 16,
  parameter int ENQ_W  = 2,
  parameter int DEQ_W  = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int EW = $clog2(ENQ_W + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state_q, state_next;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];

  logic          run;
  logic          enq_ready;
  logic          enq_fire;
  logic [CW-1:0] enq_add;
  logic [CW-1:0] deq_ext;
  logic [CW-1:0] eff;

  assign run       = (state_q == RUN);
  assign enq_ready = run && ((CW'(DEPTH) - count_q) >= CW'(ENQ_W));
  assign enq_fire  = bus.imem_resp && (bus.enq_cnt != '0) && enq_ready && !bus.flush;
  assign enq_add   = enq_fire ? CW'(bus.enq_cnt) : '0;

  // Over-asking consumers are clamped to what is actually held.
  assign deq_ext = CW'(bus.deq_cnt);
  assign eff     = !run ? '0 : ((deq_ext > count_q) ? count_q : deq_ext);

  always_comb begin
    state_next = state_q;
    case (state_q)
      RUN: begin
        if (bus.flush && bus.req_inflight && !bus.imem_resp) state_next = DRAIN;
      end
      DRAIN: begin
        if (!bus.flush && bus.imem_resp) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_next;
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        wr_ptr  <= wr_ptr + PW'(enq_add);
        rd_ptr  <= rd_ptr + PW'(eff);
        count_q <= count_q + enq_add - eff;
      end
    end
  end

  // Payload storage carries no reset; stale slots are hidden by deq_valid.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (EW'(i) < bus.enq_cnt) begin
          mem_data[wr_ptr + PW'(i)] <= bus.enq_data[i*DATA_W +: DATA_W];
          mem_pc[wr_ptr + PW'(i)]   <= bus.enq_pc[i*PC_W +: PC_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !bus.flush && run) begin
      assert (deq_ext <= count_q)
        else $error("fetch_queue: deq_cnt %0d exceeds count %0d", bus.deq_cnt, count_q);
    end
  end

  always_comb begin
    bus.deq_valid = '0;
    bus.deq_data  = '0;
    bus.deq_pc    = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      if (run && (count_q > CW'(i))) begin
        bus.deq_valid[i]                 = 1'b1;
        bus.deq_data[i*DATA_W +: DATA_W] = mem_data[rd_ptr + PW'(i)];
        bus.deq_pc[i*PC_W +: PC_W]       = mem_pc[rd_ptr + PW'(i)];
      end
    end
  end

  assign bus.enq_ready = enq_ready;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CW'(DEPTH));
  assign bus.empty     = (count_q == '0);
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 16;
  localparam int ENQ_W  = 2;
  localparam int DEQ_W  = 2;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  fetch_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) bus ();

  fetch_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.flush        = 1'b0;
    bus.req_inflight = 1'b0;
    bus.imem_resp    = 1'b0;
    bus.enq_cnt      = '0;
    bus.enq_data     = '0;
    bus.enq_pc       = '0;
    bus.deq_cnt      = '0;
  endtask

  task automatic drive_enq(input int n, input logic [31:0] pc0, input logic [31:0] pc1);
    bus.imem_resp = 1'b1;
    bus.enq_cnt   = 2'(n);
    bus.enq_pc    = {pc1, pc0};
    bus.enq_data  = {~pc1, ~pc0};
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.count); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", bus.full); end
    vectors++; if (bus.deq_valid !== 2'b00) begin miscompares++; $display("FAIL reset_deq_valid got %b want 00", bus.deq_valid); end
    vectors++; if (bus.deq_pc !== 64'h0 || bus.deq_data !== 64'h0) begin miscompares++; $display("FAIL reset_deq_lanes got pc %h data %h want 0", bus.deq_pc, bus.deq_data); end
    vectors++; if (bus.enq_ready !== 1'b1) begin miscompares++; $display("FAIL reset_enq_ready got %b want 1", bus.enq_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    drive_enq(2, 32'h100, 32'h104);
    #1;
    vectors++; if (bus.deq_valid !== 2'b00) begin miscompares++; $display("FAIL basic_no_bypass got %b want 00", bus.deq_valid); end
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd2) begin miscompares++; $display("FAIL basic_count got %0d want 2", bus.count); end
    vectors++; if (bus.deq_valid !== 2'b11) begin miscompares++; $display("FAIL basic_deq_valid got %b want 11", bus.deq_valid); end
    vectors++; if (bus.deq_pc !== {32'h104, 32'h100}) begin miscompares++; $display("FAIL basic_deq_pc got %h want 0000010400000100", bus.deq_pc); end
    vectors++; if (bus.deq_data !== {~32'h104, ~32'h100}) begin miscompares++; $display("FAIL basic_deq_data got %h want %h", bus.deq_data, {~32'h104, ~32'h100}); end
    bus.deq_cnt = 2'd2;
    tick();
    drive_idle();
    vectors++; if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin miscompares++; $display("FAIL basic_drain got empty %b count %0d want 1 0", bus.empty, bus.count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_enq(2, 32'h200 + 32'(8*k), 32'h204 + 32'(8*k));
      tick();
    end
    drive_idle();
    vectors++; if (bus.count !== 5'd14 || bus.enq_ready !== 1'b1 || bus.full !== 1'b0) begin miscompares++; $display("FAIL fill14 got count %0d ready %b full %b want 14 1 0", bus.count, bus.enq_ready, bus.full); end
    drive_enq(2, 32'h238, 32'h23C);
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.enq_ready !== 1'b0) begin miscompares++; $display("FAIL fill16 got count %0d full %b ready %b want 16 1 0", bus.count, bus.full, bus.enq_ready); end
    drive_enq(2, 32'hBAD0, 32'hBAD4);
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd16) begin miscompares++; $display("FAIL full_reject_count got %0d want 16", bus.count); end
    for (int k = 0; k < 8; k++) begin
      vectors++; if (bus.deq_pc !== {32'h204 + 32'(8*k), 32'h200 + 32'(8*k)}) begin miscompares++; $display("FAIL fill_order_%0d got %h want %h", k, bus.deq_pc, {32'h204 + 32'(8*k), 32'h200 + 32'(8*k)}); end
      bus.deq_cnt = 2'd2;
      tick();
      drive_idle();
    end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL fill_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_enq(2, 32'h300 + 32'(8*k), 32'h304 + 32'(8*k));
      tick();
    end
    drive_idle();
    for (int k = 0; k < 7; k++) begin
      bus.deq_cnt = 2'd2;
      tick();
    end
    drive_idle();
    drive_enq(2, 32'h400, 32'h404);
    tick();
    drive_enq(2, 32'h408, 32'h40C);
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", bus.count); end
    vectors++; if (bus.deq_pc !== {32'h404, 32'h400}) begin miscompares++; $display("FAIL wrap_pc_a got %h want 0000040400000400", bus.deq_pc); end
    bus.deq_cnt = 2'd2;
    tick();
    drive_idle();
    vectors++; if (bus.deq_pc !== {32'h40C, 32'h408}) begin miscompares++; $display("FAIL wrap_pc_b got %h want 0000040c00000408", bus.deq_pc); end
    vectors++; if (bus.deq_data !== {~32'h40C, ~32'h408}) begin miscompares++; $display("FAIL wrap_data_b got %h want %h", bus.deq_data, {~32'h40C, ~32'h408}); end
    bus.deq_cnt = 2'd2;
    tick();
    drive_idle();
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_enq(1, 32'h500, 32'hEEE);
    tick();
    drive_idle();
    vectors++; if (bus.deq_valid !== 2'b01 || bus.count !== 5'd1) begin miscompares++; $display("FAIL single_lane got valid %b count %0d want 01 1", bus.deq_valid, bus.count); end
    vectors++; if (bus.deq_pc !== {32'h0, 32'h500} || bus.deq_data[63:32] !== 32'h0) begin miscompares++; $display("FAIL single_lane_mask got pc %h data %h", bus.deq_pc, bus.deq_data); end
    drive_enq(2, 32'h504, 32'h508);
    tick();
    drive_enq(2, 32'h50C, 32'h510);
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd5) begin miscompares++; $display("FAIL simul_pre_count got %0d want 5", bus.count); end
    drive_enq(2, 32'h514, 32'h518);
    bus.deq_cnt = 2'd1;
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd6) begin miscompares++; $display("FAIL simul_count got %0d want 6", bus.count); end
    vectors++; if (bus.deq_pc !== {32'h508, 32'h504}) begin miscompares++; $display("FAIL simul_head got %h want 0000050800000504", bus.deq_pc); end
  endtask

  task automatic test_flush_drain();
    bus.flush        = 1'b1;
    bus.req_inflight = 1'b1;
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin miscompares++; $display("FAIL drain_count got %0d empty %b want 0 1", bus.count, bus.empty); end
    vectors++; if (bus.enq_ready !== 1'b0 || bus.deq_valid !== 2'b00) begin miscompares++; $display("FAIL drain_state got ready %b valid %b want 0 00", bus.enq_ready, bus.deq_valid); end
    bus.flush        = 1'b1;
    bus.req_inflight = 1'b1;
    tick();
    drive_idle();
    vectors++; if (bus.enq_ready !== 1'b0) begin miscompares++; $display("FAIL drain_reflush got ready %b want 0", bus.enq_ready); end
    drive_enq(2, 32'h900, 32'h904);
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd0 || bus.enq_ready !== 1'b1) begin miscompares++; $display("FAIL drain_discard got count %0d ready %b want 0 1", bus.count, bus.enq_ready); end
    drive_enq(2, 32'hA00, 32'hA04);
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd2 || bus.deq_pc[31:0] !== 32'hA00) begin miscompares++; $display("FAIL drain_resume got count %0d pc %h want 2 a00", bus.count, bus.deq_pc[31:0]); end
  endtask

  task automatic test_flush_with_resp();
    drive_enq(2, 32'hB00, 32'hB04);
    bus.flush        = 1'b1;
    bus.req_inflight = 1'b1;
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd0 || bus.enq_ready !== 1'b1 || bus.deq_valid !== 2'b00) begin miscompares++; $display("FAIL flush_resp got count %0d ready %b valid %b want 0 1 00", bus.count, bus.enq_ready, bus.deq_valid); end
    drive_enq(2, 32'hC00, 32'hC04);
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd2 || bus.deq_pc !== {32'hC04, 32'hC00}) begin miscompares++; $display("FAIL flush_resp_next got count %0d pc %h want 2 00000c0400000c00", bus.count, bus.deq_pc); end
  endtask

  task automatic test_reset_in_drain();
    bus.flush        = 1'b1;
    bus.req_inflight = 1'b1;
    tick();
    drive_idle();
    vectors++; if (bus.enq_ready !== 1'b0) begin miscompares++; $display("FAIL rdrain_enter got ready %b want 0", bus.enq_ready); end
    drive_enq(2, 32'hE00, 32'hE04);
    bus.flush = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive_idle();
    vectors++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin miscompares++; $display("FAIL rdrain_count got %0d empty %b full %b want 0 1 0", bus.count, bus.empty, bus.full); end
    vectors++; if (bus.enq_ready !== 1'b1 || bus.deq_valid !== 2'b00 || bus.deq_pc !== 64'h0) begin miscompares++; $display("FAIL rdrain_outputs got ready %b valid %b pc %h want 1 00 0", bus.enq_ready, bus.deq_valid, bus.deq_pc); end
    drive_enq(2, 32'hD00, 32'hD04);
    tick();
    drive_idle();
    vectors++; if (bus.count !== 5'd2 || bus.deq_pc[31:0] !== 32'hD00) begin miscompares++; $display("FAIL rdrain_resume got count %0d pc %h want 2 d00", bus.count, bus.deq_pc[31:0]); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    drive_idle();
    tick();
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush_drain();
    test_flush_with_resp();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised multi-lane instruction queue between instruction fetch and decode/dispatch in the out-of-order core. It accepts up to ENQ_W fetched instructions (data + PC) per cycle and presents up to DEQ_W oldest entries per cycle in show-ahead form. It supports a branch-mispredict flush with stale-response squashing: if an imem request is in flight at flush time, its response is dropped instead of being enqueued.

## Interface
- DATA_W, 32: instruction bits per entry
- PC_W, 32: PC bits per entry
- DEPTH, 16: entries; power of two, ≥ max(ENQ_W, DEQ_W), ≥ 2
- ENQ_W, 2: enqueue lanes; ≥ 1
- DEQ_W, 2: dequeue lanes; ≥ 1
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- flush  in  1  mispredict flush; empties queue
- req_inflight  in  1  fetch has an imem request outstanding, not yet answered
- imem_resp  in  1  imem response this cycle
- enq_cnt  in  $clog2(ENQ_W+1)  lanes offered this cycle (lane 0 oldest); only meaningful with imem_resp
- enq_data  in  ENQ_W*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- enq_pc  in  ENQ_W*PC_W  lane i PC, same packing
- enq_ready  out  1  free entries ≥ ENQ_W and state RUN
- deq_cnt  in  $clog2(DEQ_W+1)  entries consumed this cycle, oldest first
- deq_valid  out  DEQ_W  bit i set iff count > i and state RUN
- deq_data  out  DEQ_W*DATA_W  lane i = i-th oldest entry; 0 when lane invalid
- deq_pc  out  DEQ_W*PC_W  same, PCs
- count  out  $clog2(DEPTH+1)  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH-entry circular buffer. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A separate count register disambiguates full from empty.
- Enqueue fires when imem_resp && enq_cnt>0 && enq_ready && !flush && state==RUN. Lanes 0..enq_cnt-1 are written to wr_ptr, wr_ptr+1, ... (mod DEPTH). wr_ptr advances by enq_cnt.
- Acceptance is all-or-nothing. With enq_ready=0, no lane is written, and fetch must hold and replay.
- Dequeue: eff = min(deq_cnt, count). rd_ptr advances by eff. deq_cnt > count is a protocol error: flag it by assertion; the RTL clamps.
- Both in one cycle: count_next = count + enq_fired_cnt − eff. enq_ready uses the current count only and ignores same-cycle dequeue.
- States:
  - RUN: normal operation.
  - DRAIN: waiting to discard one stale response. No enqueue, deq_valid=0, enq_ready=0.
- Transitions:
  - RUN→DRAIN: flush && req_inflight && !imem_resp.
  - RUN→RUN: flush otherwise. A response in the flush cycle is itself dropped.
  - DRAIN→RUN: imem_resp; that response is discarded.
  - DRAIN + flush: stay in DRAIN.
- Flush, in any state: pointers and count go to 0 next cycle. Flush dominates enqueue and dequeue in the same cycle. Entry contents need not be cleared, since outputs are masked by deq_valid.

## Timing
- Reset (rst=0 at clk edge): state RUN, pointers 0, count 0, empty=1, full=0, deq_valid=0, deq_data/deq_pc=0, enq_ready=1.
- Reset takes priority over flush and all other inputs, including mid-DRAIN.
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N appears on deq lanes after edge N, with no same-cycle bypass.
- deq_* and enq_ready are combinational from registered state only, with no input-to-output path.
- full, empty and count are registered-derived and update the cycle after the event.
- Wrap-around: multi-lane writes and reads crossing index DEPTH−1→0 must be contiguous modulo DEPTH.

## Test plan
- Reset, then enqueue 2 lanes (PC 0x100, 0x104) → next cycle count=2, deq_valid=2'b11, deq_pc lanes = 0x100, 0x104; deq_cnt=2 → empty=1 after one cycle.
- DEPTH=16, ENQ_W=2: enqueue 7 pairs with no dequeue → count=14, enq_ready=1. Enqueue one more pair → count=16, full=1, enq_ready=0. Offered pair at full → not written, count stays 16.
- Pointer wrap: fill 14, dequeue 14, enqueue pairs at indices 14,15 then 0,1 → deq order follows PCs exactly across the wrap.
- Simultaneous enqueue of 2 and deq_cnt=1 at count=5 → count=6. deq_cnt=3 at count=1 (DEQ_W≥3 build) → clamp, count=0, assertion fires.
- Flush with req_inflight=1, imem_resp=0 → count=0, DRAIN. Next imem_resp with enq_cnt=2 → dropped, back to RUN, count=0. Following response is enqueued normally.
- Flush and imem_resp in the same cycle → response dropped, state RUN. rst=0 while in DRAIN → state RUN, all outputs at reset values.
